// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the instruction fetch unit.
// Rev 1.0
`default_nettype none

package fetch_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// fetch_fifo -- 2-entry {pc, instr} queue between fetch and decode, with flush.
// Rev 1.0
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         do_pop;
  logic         do_push;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit -- in-order instruction fetch with redirect and stale-response drain.
// Rev 1.0
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [1:0]       outst_q, outst_d;
  logic [1:0]       drop_q, drop_d;
  logic [1:0][31:0] pcq_q, pcq_d;
  logic [1:0]       outst_tmp;
  logic [1:0]       fifo_count;
  logic [2:0]       inflight;
  logic             fifo_push, fifo_pop, fifo_flush;
  logic             req_fire, resp_take;
  fetch_entry_t     fifo_head, fifo_in;
  logic [1:0]       unused_tgt_lsbs;

  assign unused_tgt_lsbs = redirect_target[1:0];

  // Every request owns a FIFO slot up front, so responses can never overflow it.
  assign inflight       = {1'b0, outst_q} + {1'b0, fifo_count};
  assign imem_req_valid = !reset && (state_q == ST_RUN) && (inflight < 3'd2) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_take      = imem_resp_valid && (outst_q != 2'd0);

  assign fifo_in  = '{pc: pcq_q[0], instr: imem_resp_data};
  assign fifo_pop = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    pcq_d      = pcq_q;
    outst_tmp  = outst_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (redirect_valid) begin
      fifo_flush = 1'b1;
      pcq_d      = '0;
      fetch_pc_d = {redirect_target[31:2], 2'b00};
      drop_d     = outst_q - {1'b0, resp_take};
      outst_d    = drop_d;
      state_d    = (drop_d != 2'd0) ? ST_DRAIN : ST_RUN;
    end else if (state_q == ST_DRAIN) begin
      if (resp_take) begin
        drop_d  = drop_q - 2'd1;
        outst_d = outst_q - 2'd1;
        if (drop_q == 2'd1) begin
          state_d = ST_RUN;
        end
      end
    end else begin
      if (resp_take) begin
        fifo_push = 1'b1;
        pcq_d[0]  = pcq_q[1];
        outst_tmp = outst_q - 2'd1;
      end
      if (req_fire) begin
        pcq_d[outst_tmp[0]] = fetch_pc_q;
        outst_tmp           = outst_tmp + 2'd1;
        fetch_pc_d          = fetch_pc_q + 32'd4;
      end
      outst_d = outst_tmp;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_VECTOR;
      outst_q    <= 2'd0;
      drop_q     <= 2'd0;
      pcq_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      pcq_q      <= pcq_d;
    end
  end

  fetch_fifo u_fifo (
    .clk_i        (clock),
    .rst_i        (reset),
    .flush_i      (fifo_flush),
    .push_i       (fifo_push),
    .push_entry_i (fifo_in),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .count_o      (fifo_count)
  );

  assign instr_valid = (fifo_count != 2'd0);
  assign instruction = instr_valid ? fifo_head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? fifo_head.pc : 32'h0000_0000;

endmodule

`default_nettype wire
